// File: rtl/dmem_responder.sv
// Byte-wide data memory for the matrix-multiplier core: core port with one-cycle
// read latency, a host load/peek port, and a handshaked streaming dump engine.
module dmem_responder #(
  parameter int unsigned DEPTH = 4096,
  parameter int unsigned AW    = 16
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_core_busy,
  input  logic [AW-1:0] i_dram_addr,
  input  logic          i_dram_read,
  input  logic          i_dram_write,
  input  logic [7:0]    i_dram_wdata,
  output logic [7:0]    o_dram_rdata,
  input  logic [AW-1:0] i_host_addr,
  input  logic          i_host_we,
  input  logic          i_host_re,
  input  logic [7:0]    i_host_wdata,
  output logic [7:0]    o_host_rdata,
  output logic          o_host_valid,
  output logic          o_host_err,
  input  logic          i_dump_start,
  input  logic [AW-1:0] i_dump_base,
  input  logic [AW-1:0] i_dump_len,
  output logic [7:0]    o_dump_data,
  output logic          o_dump_valid,
  input  logic          i_dump_ready,
  output logic          o_dump_done
);

  localparam int unsigned IW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_OUT  = 2'd2
  } state_t;

  state_t        state;
  logic [AW-1:0] ptr;
  logic [AW-1:0] cnt;

  logic [7:0]    mem [DEPTH];

  logic [IW-1:0] core_idx;
  logic [IW-1:0] host_idx;
  logic [IW-1:0] dump_idx;
  logic          core_wr;
  logic          core_rd;
  logic          host_ok;
  logic          host_wr;
  logic          host_rd;
  logic          host_drop;
  logic          unused_addr;

  // Addresses wrap modulo DEPTH by keeping only the low index bits.
  assign core_idx    = i_dram_addr[IW-1:0];
  assign host_idx    = i_host_addr[IW-1:0];
  assign dump_idx    = ptr[IW-1:0];
  assign unused_addr = ^{i_dram_addr, i_host_addr, ptr};

  // Busy flag arbitrates: core owns memory when busy, host/dump otherwise.
  always_comb begin
    core_wr   = i_core_busy && i_dram_write;
    core_rd   = i_core_busy && i_dram_read;
    host_ok   = !i_core_busy && (state == S_IDLE);
    host_wr   = host_ok && i_host_we;
    host_rd   = host_ok && i_host_re && !i_host_we;
    host_drop = (i_host_we || i_host_re) && !host_ok;
  end

  // Storage array; contents are deliberately not reset.
  always_ff @(posedge i_clk) begin
    if (core_wr) begin
      mem[core_idx] <= i_dram_wdata;
    end else if (host_wr) begin
      mem[host_idx] <= i_host_wdata;
    end
  end

  // Read ports, host handshakes and the dump FSM.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state        <= S_IDLE;
      ptr          <= '0;
      cnt          <= '0;
      o_dram_rdata <= 8'h00;
      o_host_rdata <= 8'h00;
      o_host_valid <= 1'b0;
      o_host_err   <= 1'b0;
      o_dump_data  <= 8'h00;
      o_dump_valid <= 1'b0;
      o_dump_done  <= 1'b0;
    end else begin
      o_host_valid <= host_rd;
      o_host_err   <= host_drop;
      o_dump_done  <= 1'b0;

      if (core_rd) begin
        o_dram_rdata <= mem[core_idx];
      end
      if (host_rd) begin
        o_host_rdata <= mem[host_idx];
      end

      case (state)
        S_IDLE: begin
          if (i_dump_start) begin
            ptr <= i_dump_base;
            cnt <= i_dump_len;
            if (i_dump_len == '0) begin
              o_dump_done <= 1'b1;
            end else begin
              state <= S_RD;
            end
          end
        end
        S_RD: begin
          if (!i_core_busy) begin
            o_dump_data  <= mem[dump_idx];
            o_dump_valid <= 1'b1;
            state        <= S_OUT;
          end
        end
        S_OUT: begin
          // Valid stays up regardless of busy until the consumer takes the byte.
          if (i_dump_ready) begin
            o_dump_valid <= 1'b0;
            ptr          <= ptr + AW'(1);
            cnt          <= cnt - AW'(1);
            if (cnt == AW'(1)) begin
              o_dump_done <= 1'b1;
              state       <= S_IDLE;
            end else begin
              state <= S_RD;
            end
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder for the matrix-multiplier core: a synchronous byte RAM that services the core's DRAM read/write strobes with fixed one-cycle read latency. It also exposes a host port for single-byte load/peek and a streaming dump engine for reading result matrices out after a run. It sits between the core's DRAM interface and the testbench/host loader. Memory access arbitration is keyed on the core's busy flag.

## Interface
Parameters:
- DEPTH, 4096, number of bytes stored; must be a power of two ≤ 65536
- AW, 16, address width on all ports

Ports:
- i_clk  input  1  clock; all state updates on rising edge
- i_rst  input  1  reset, synchronous, active-high
- i_core_busy  input  1  core busy flag; 1 = core owns the memory
- i_dram_addr  input  16  core byte address
- i_dram_read  input  1  core read strobe
- i_dram_write  input  1  core write strobe
- i_dram_wdata  input  8  core write data
- o_dram_rdata  output  8  read data returned to the core
- i_host_addr  input  16  host byte address
- i_host_we  input  1  host write strobe
- i_host_re  input  1  host read strobe
- i_host_wdata  input  8  host write data
- o_host_rdata  output  8  host read data
- o_host_valid  output  1  one-cycle pulse: o_host_rdata is valid
- o_host_err  output  1  one-cycle pulse: host access dropped
- i_dump_start  input  1  one-cycle pulse: start a dump
- i_dump_base  input  16  dump start address, sampled on start
- i_dump_len  input  16  number of bytes to dump, sampled on start
- o_dump_data  output  8  streamed byte
- o_dump_valid  output  1  o_dump_data is valid
- i_dump_ready  input  1  consumer accepts the byte
- o_dump_done  output  1  one-cycle pulse: dump finished

## Operation
- Addressing:
  - Every address uses its low log2(DEPTH) bits, so addresses wrap modulo DEPTH.
  - Memory contents are not reset.
- Core port, active only while i_core_busy=1:
  - A write stores i_dram_wdata.
  - A read loads o_dram_rdata, which holds its value until the next core read.
  - A read and a write in the same cycle to the same address: the write commits and o_dram_rdata returns the old byte (read-before-write).
  - Core strobes are ignored while i_core_busy=0.
- Host port, active only while i_core_busy=0 and the dump FSM is IDLE:
  - A host write stores i_host_wdata.
  - A host read loads o_host_rdata and pulses o_host_valid.
  - i_host_we and i_host_re asserted together: the write wins and no valid pulse is produced.
  - A host strobe arriving while the core is busy or a dump is active is dropped; o_host_err pulses and memory is unchanged.
- Dump FSM states: IDLE, RD, OUT.
  - IDLE: on i_dump_start, latch ptr=i_dump_base, cnt=i_dump_len. If len=0, pulse o_dump_done next cycle and stay in IDLE; otherwise go to RD.
  - RD: if i_core_busy=0, read mem[ptr] into o_dump_data and go to OUT. If i_core_busy=1, stall in RD.
  - OUT: o_dump_valid=1 and o_dump_data is held stable. On the cycle with i_dump_ready=1: ptr=ptr+1 (wrapping), cnt=cnt−1. If cnt becomes 0, pulse o_dump_done and go to IDLE; otherwise go to RD.
  - i_dump_start outside IDLE is ignored.
- Reset mid-operation forces IDLE. A partial dump is abandoned with no done pulse.

## Timing
- Reset values:
  - o_dram_rdata=0, o_host_rdata=0, o_dump_data=0
  - o_host_valid=0, o_host_err=0, o_dump_valid=0, o_dump_done=0
  - FSM=IDLE, ptr=0, cnt=0
- Core read: strobe sampled at edge N; data valid after edge N, i.e. usable during cycle N+1.
- Core write at edge N: a read of the same address at edge N+1 returns the new byte.
- Host read: o_host_valid pulses high for exactly the cycle after the strobe edge.
- Dump throughput: minimum 2 cycles per byte (RD then OUT). A dump of L bytes with ready tied high takes 2L cycles from the start edge to the done edge.
- o_dump_valid is never deasserted before its handshake, including when i_core_busy rises while in OUT.
- o_dump_done and o_host_err are single-cycle pulses.

## Test plan
- Core write 0xA5 to address 0x0010, read it back next cycle (busy=1) -> o_dram_rdata=0xA5 one cycle after the read strobe, and it holds while no further read is issued.
- Same-cycle core read+write of 0x3C to address 5, which previously held 0x11 -> o_dram_rdata=0x11 that cycle; a read on the following cycle returns 0x3C.
- Host write 0x77 to address 0x1003 with DEPTH=4096, then host read of address 0x0003 -> o_host_valid pulses with o_host_rdata=0x77 (wrap). Repeat the host write with busy=1 -> o_host_err pulse, memory unchanged.
- Preload addresses 0x20..0x23 with 1,2,3,4, dump base=0x20 len=4, ready toggling 1,0,1,... -> the stream 1,2,3,4 each held until accepted, followed by one done pulse.
- Dump len=3 with busy raised in the middle of RD for 5 cycles -> FSM stalls with no data corruption or lost bytes. Dump len=0 -> done pulse the next cycle with valid never asserted.
- Assert i_rst mid-dump -> all outputs 0 on the next cycle and FSM in IDLE. A new dump starts cleanly afterwards.
